// File: rtl/priority_encoder.sv
// priority_encoder: registered N-bit leading-one (most-significant set bit) encoder.
// One-cycle latency. The registered enable gates the index output.
// Build option: define PRIORITY_ENCODER_TRISTATE_EN so that a disabled encoder
// releases `i` to high impedance, which lets several encoders share one index bus.
// Without it, a disabled encoder drives `i` to all zeros.
module priority_encoder #(
  parameter int N = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         n,
  output logic [$clog2(N)-1:0] i,
  output logic                 zero
);

  localparam int W = $clog2(N);

  // Scan from the LSB upward. A later hit overwrites an earlier one, so the
  // highest set bit wins. An all-zero word yields index 0.
  function automatic logic [W-1:0] msb_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      if (v[k]) idx = W'(k);
    end
    return idx;
  endfunction

  logic         en_d,   en_q;
  logic [W-1:0] idx_d,  idx_q;
  logic         zero_d, zero_q;

  // Next-state: capture a new encoding only while enabled; the index holds otherwise.
  always_comb begin
    en_d   = en;
    idx_d  = idx_q;
    zero_d = 1'b0;
    if (en) begin
      idx_d  = msb_index(n);
      zero_d = (n == '0);
    end
  end

  // Input sample -> output register boundary
  // State register: asynchronous active-low reset clears enable, index and zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      idx_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      en_q   <= en_d;
      idx_q  <= idx_d;
      zero_q <= zero_d;
    end
  end

  // The output gate is driven from the registered enable only, so a stale
  // index can never appear when the raw enable rises.
`ifdef PRIORITY_ENCODER_TRISTATE_EN
  assign i = en_q ? idx_q : 'z;
`else
  assign i = en_q ? idx_q : '0;
`endif

  assign zero = zero_q;

endmodule

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder: directed table vectors plus a random sweep for
// priority_encoder. Three instances are used: N = 255, N = 8 and N = 256.
module tb_priority_encoder;

`ifdef PRIORITY_ENCODER_TRISTATE_EN
  localparam logic OFF_BIT = 1'bz;
`else
  localparam logic OFF_BIT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [254:0] n255;
  logic [7:0]   n8;
  logic [255:0] n256;
  logic [7:0]   i255;
  logic [2:0]   i8;
  logic [7:0]   i256;
  logic         zero255, zero8, zero256;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  priority_encoder #(.N(255)) dut255 (
    .clk(clk), .rst_n(rst_n), .en(en), .n(n255), .i(i255), .zero(zero255));
  priority_encoder #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .n(n8), .i(i8), .zero(zero8));
  priority_encoder #(.N(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .en(en), .n(n256), .i(i256), .zero(zero256));

  typedef struct {
    string        name;
    logic         en;
    logic [254:0] n;
    int           exp_idx;
    logic         exp_zero;
    logic         exp_off;
  } vec_t;

  vec_t vecs[13];

  // Expected index, w bits wide, zero-extended to 8 bits. It shows the
  // disabled level when off.
  function automatic logic [7:0] exp_i(input int w, input logic off, input int idx);
    logic [7:0] r;
    r = 8'(idx);
    if (off) begin
      for (int b = 0; b < w; b++) r[b] = OFF_BIT;
    end
    return r;
  endfunction

  // Reference model: scan downward from the top bit and take the first hit.
  function automatic int ref_msb(input logic [255:0] v, input int width);
    for (int k = width - 1; k >= 0; k--) begin
      if (v[k]) return k;
    end
    return 0;
  endfunction

  task automatic chk_i(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: i got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_z(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: zero got %b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after the next rising edge.
  task automatic apply(input logic e, input logic [254:0] v, input logic [7:0] v8,
                       input logic [255:0] v256);
    en   = e;
    n255 = v;
    n8   = v8;
    n256 = v256;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] r;
    logic         e;
    logic [254:0] v;
    logic [7:0]   v8;
    logic [255:0] v256;

    vecs[0]  = '{"n_zero",   1'b1, 255'h0,                    0,   1'b1, 1'b0};
    vecs[1]  = '{"n_one",    1'b1, 255'h1,                    0,   1'b0, 1'b0};
    vecs[2]  = '{"n_F",      1'b1, 255'hF,                    3,   1'b0, 1'b0};
    vecs[3]  = '{"n_FF",     1'b1, 255'hFF,                   7,   1'b0, 1'b0};
    vecs[4]  = '{"n_FFF",    1'b1, 255'hFFF,                  11,  1'b0, 1'b0};
    vecs[5]  = '{"n_FFFF",   1'b1, 255'hFFFF,                 15,  1'b0, 1'b0};
    vecs[6]  = '{"n_FFFFF",  1'b1, 255'hFFFFF,                19,  1'b0, 1'b0};
    vecs[7]  = '{"all_ones", 1'b1, {255{1'b1}},               254, 1'b0, 1'b0};
    vecs[8]  = '{"top_bit",  1'b1, 255'h1 << 254,             254, 1'b0, 1'b0};
    vecs[9]  = '{"bit100",   1'b1, (255'h1 << 100) | 255'h5,  100, 1'b0, 1'b0};
    vecs[10] = '{"pre_dis",  1'b1, 255'hFF,                   7,   1'b0, 1'b0};
    vecs[11] = '{"disabled", 1'b0, 255'hFF,                   0,   1'b0, 1'b1};
    vecs[12] = '{"reenable", 1'b1, 255'hF,                    3,   1'b0, 1'b0};

    // Reset asserted before any clock edge
    rst_n = 1'b0;
    en    = 1'b0;
    n255  = '0;
    n8    = '0;
    n256  = '0;
    #1;
    chk_i("reset_i", i255, exp_i(8, 1'b1, 0));
    chk_z("reset_zero", zero255, 1'b0);
    #12 rst_n = 1'b1;
    apply(1'b0, 255'h0, 8'h0, 256'h0);
    chk_i("idle_i", i255, exp_i(8, 1'b1, 0));
    chk_z("idle_zero", zero255, 1'b0);

    // Directed table
    for (int t = 0; t < 13; t++) begin
      apply(vecs[t].en, vecs[t].n, 8'h0, 256'h0);
      chk_i(vecs[t].name, i255, exp_i(8, vecs[t].exp_off, vecs[t].exp_idx));
      chk_z(vecs[t].name, zero255, vecs[t].exp_zero);
    end

    // Asynchronous reset mid-stream takes effect without a clock edge
    apply(1'b1, 255'h0, 8'h0, 256'h0);
    chk_z("pre_rst_zero", zero255, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_i("async_rst_i", i255, exp_i(8, 1'b1, 0));
    chk_z("async_rst_zero", zero255, 1'b0);
    #1 rst_n = 1'b1;
    apply(1'b1, 255'hF, 8'h0, 256'h0);
    chk_i("post_rst_i", i255, exp_i(8, 1'b0, 3));
    chk_z("post_rst_zero", zero255, 1'b0);

    // Random sweep over all three widths
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      e    = ($urandom_range(0, 3) != 0);
      v    = r[254:0] >> $urandom_range(0, 254);
      if ($urandom_range(0, 15) == 0) v = '0;
      v8   = 8'($urandom_range(0, 255)) >> $urandom_range(0, 7);
      v256 = r >> $urandom_range(0, 255);
      if ($urandom_range(0, 15) == 0) v256 = '0;
      apply(e, v, v8, v256);
      chk_i("rand255_i", i255, exp_i(8, !e, ref_msb({1'b0, v}, 255)));
      chk_z("rand255_zero", zero255, e && (v == '0));
      chk_i("rand8_i", {5'b0, i8}, exp_i(3, !e, ref_msb({248'b0, v8}, 8)));
      chk_z("rand8_zero", zero8, e && (v8 == '0));
      chk_i("rand256_i", i256, exp_i(8, !e, ref_msb(v256, 256)));
      chk_z("rand256_zero", zero256, e && (v256 == '0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
